split_timestamp: RTL and testbench



---
 rtl/split_timestamp_pkg.sv | 14 +
 rtl/split_timestamp_if.sv | 14 +
 rtl/split_timestamp_beat_delay_line.sv | 57 +++++
 rtl/split_timestamp.sv | 127 ++++++++++++
 tb/tb_split_timestamp.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/split_timestamp_pkg.sv
// Shared definitions for the ATS timestamp split path.
package split_timestamp_pkg;

    typedef enum logic {
        ST_RECV   = 1'b0,
        ST_TS_OUT = 1'b1
    } state_t;

    // Number of data beats a timestamp occupies at the tail of a packet.
    function automatic int ts_beats(input int ts_width, input int data_width);
        return ts_width / data_width;
    endfunction

endpackage

// File: rtl/split_timestamp_if.sv
// AXI4-Stream bundle used for the input, frame and timestamp ports.
interface split_timestamp_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/split_timestamp_beat_delay_line.sv
// Depth-D beat shift register with fill counter; entry 0 is the oldest beat.
// Data of every entry is exposed flattened (entry 0 in the low bits).
module split_timestamp_beat_delay_line #(
    parameter int DW    = 8,
    parameter int KW    = 1,
    parameter int DEPTH = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DW-1:0]         din_data,
    input  logic [KW-1:0]         din_keep,
    output logic [DEPTH*DW-1:0]   line_data,
    output logic [KW-1:0]         head_keep,
    output logic [CNT_W-1:0]      cnt
);
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0][KW-1:0] keep_q;
    logic [CNT_W-1:0]         cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            keep_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_q[i] <= data_q[i+1];
                keep_q[i] <= keep_q[i+1];
            end
            if (push) begin
                data_q[DEPTH-1] <= din_data;
                keep_q[DEPTH-1] <= din_keep;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    data_q[i] <= din_data;
                    keep_q[i] <= din_keep;
                end
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign line_data = data_q;
    assign head_keep = keep_q[0];
    assign cnt       = cnt_q;

endmodule

// File: rtl/split_timestamp.sv
// Splits an ingress [frame][timestamp] AXI4-Stream packet into a frame stream with
// a corrected tlast and a single-word timestamp stream; runt packets are dropped.
module split_timestamp
    import split_timestamp_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int TIMESTAMP_WIDTH    = 72
) (
    input  logic              clk,
    input  logic              rstn,
    split_timestamp_if.slave  s_axis,
    split_timestamp_if.master m_axis,
    split_timestamp_if.master m_axis_timestamp,
    output logic              runt_drop
);
    localparam int DW    = C_AXIS_TDATA_WIDTH;
    localparam int KW    = C_AXIS_TKEEP_WIDTH;
    localparam int D     = ts_beats(TIMESTAMP_WIDTH, DW);
    localparam int CNT_W = $clog2(D + 1);

    state_t                     state_q, state_d;
    logic                       live_q;
    logic [TIMESTAMP_WIDTH-1:0] ts_q;
    logic                       runt_q;

    logic                       push, pop, flush, capture, runt_d;
    logic                       s_ready, m_valid, ts_valid, full, accept;
    logic [D*DW-1:0]            line_data;
    logic [KW-1:0]              head_keep;
    logic [CNT_W-1:0]           cnt;
    logic [(D+1)*DW-1:0]        ts_window;

    split_timestamp_beat_delay_line #(
        .DW    (DW),
        .KW    (KW),
        .DEPTH (D),
        .CNT_W (CNT_W)
    ) u_line (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .din_data  (s_axis.tdata),
        .din_keep  (s_axis.tkeep),
        .line_data (line_data),
        .head_keep (head_keep),
        .cnt       (cnt)
    );

    assign full = (cnt == CNT_W'(D));
    // On the tlast beat, entries 1..D-1 plus the incoming beat form the timestamp.
    assign ts_window = {s_axis.tdata, line_data};

    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        ts_valid = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        capture  = 1'b0;
        runt_d   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_RECV: begin
                s_ready = live_q & (~full | m_axis.tready);
                m_valid = s_axis.tvalid & full;
                accept  = s_axis.tvalid & s_ready;
                if (accept) begin
                    if (s_axis.tlast) begin
                        flush = 1'b1;
                        if (full) begin
                            capture = 1'b1;
                            state_d = ST_TS_OUT;
                        end else begin
                            runt_d = 1'b1;
                        end
                    end else begin
                        push = 1'b1;
                        pop  = full;
                    end
                end
            end
            ST_TS_OUT: begin
                ts_valid = 1'b1;
                if (m_axis_timestamp.tready) begin
                    state_d = ST_RECV;
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RECV;
            live_q  <= 1'b0;
            ts_q    <= '0;
            runt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            runt_q  <= runt_d;
            if (capture) begin
                ts_q <= ts_window[(D+1)*DW-1:DW];
            end
        end
    end

    assign s_axis.tready = s_ready;

    assign m_axis.tdata  = line_data[DW-1:0];
    assign m_axis.tkeep  = head_keep;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = s_axis.tlast;

    assign m_axis_timestamp.tdata  = ts_q;
    assign m_axis_timestamp.tkeep  = '1;
    assign m_axis_timestamp.tvalid = ts_valid;
    assign m_axis_timestamp.tlast  = 1'b1;

    assign runt_drop = runt_q;

endmodule

// File: tb/tb_split_timestamp.sv
// Scoreboard bench for split_timestamp: packet-level reference model feeds expectation
// queues, negedge monitors pop and compare whatever the DUT presents.
`timescale 1ns/1ps
module tb_split_timestamp;
    localparam int DW  = 8;
    localparam int KW  = 1;
    localparam int TSW = 72;
    localparam int D   = TSW / DW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    split_timestamp_if #(.DATA_W(DW),  .KEEP_W(KW))      s_if ();
    split_timestamp_if #(.DATA_W(DW),  .KEEP_W(KW))      m_if ();
    split_timestamp_if #(.DATA_W(TSW), .KEEP_W(TSW/8))   t_if ();
    logic runt_drop;

    split_timestamp #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_AXIS_TKEEP_WIDTH (KW),
        .TIMESTAMP_WIDTH    (TSW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .m_axis_timestamp (t_if),
        .runt_drop        (runt_drop)
    );

    split_timestamp_if #(.DATA_W(64),  .KEEP_W(8))  ws_if ();
    split_timestamp_if #(.DATA_W(64),  .KEEP_W(8))  wm_if ();
    split_timestamp_if #(.DATA_W(128), .KEEP_W(16)) wt_if ();
    logic w_runt;

    split_timestamp #(
        .C_AXIS_TDATA_WIDTH (64),
        .C_AXIS_TKEEP_WIDTH (8),
        .TIMESTAMP_WIDTH    (128)
    ) dut_wide (
        .clk              (clk),
        .rstn             (rstn),
        .s_axis           (ws_if),
        .m_axis           (wm_if),
        .m_axis_timestamp (wt_if),
        .runt_drop        (w_runt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_mode = 2;   // 0 random, 1 toggle, 2 high, 3 low
    int ts_mode = 2;  // 0 random, 1 low, 2 high
    logic [9:0]     exp_frame[$];
    logic [TSW-1:0] exp_ts[$];
    logic [72:0]    wexp_frame[$];
    logic [127:0]   wexp_ts[$];
    int exp_runt = 0;
    int got_runt = 0;
    int ts_hs_cyc = -10;
    int first_cyc = 0;
    bit ts_pending = 0;
    logic [TSW-1:0] ts_prev = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=handshake", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (m_mode)
            0:       m_if.tready = 1'($urandom_range(1));
            1:       m_if.tready = ~m_if.tready;
            2:       m_if.tready = 1'b1;
            default: m_if.tready = 1'b0;
        endcase
        case (ts_mode)
            0:       t_if.tready = 1'($urandom_range(1));
            1:       t_if.tready = 1'b0;
            default: t_if.tready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (m_if.tvalid && m_if.tready) begin
                if (exp_frame.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_extra actual=%0h expected=none", m_if.tdata);
                end else begin
                    check("frame_beat", {m_if.tlast, m_if.tkeep, m_if.tdata}, exp_frame.pop_front());
                end
            end
            if (m_if.tvalid && !m_if.tready) check("s_ready_full", s_if.tready, 0);
            if (t_if.tvalid) begin
                check("s_ready_ts", s_if.tready, 0);
                if (ts_pending) check("ts_stable", t_if.tdata, ts_prev);
                if (t_if.tready) begin
                    ts_hs_cyc = cyc;
                    if (exp_ts.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ts_extra actual=%0h expected=none", t_if.tdata);
                    end else begin
                        check("timestamp", t_if.tdata, exp_ts.pop_front());
                    end
                end
            end
            ts_pending = t_if.tvalid && !t_if.tready;
            ts_prev    = t_if.tdata;
            if (runt_drop) got_runt++;

            if (wm_if.tvalid && wm_if.tready) begin
                if (wexp_frame.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wide_frame_extra actual=%0h expected=none", wm_if.tdata);
                end else begin
                    check("wide_frame", {wm_if.tlast, wm_if.tkeep, wm_if.tdata}, wexp_frame.pop_front());
                end
            end
            if (wt_if.tvalid && wt_if.tready) begin
                if (wexp_ts.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wide_ts_extra actual=%0h expected=none", wt_if.tdata);
                end else begin
                    check("wide_ts", wt_if.tdata, wexp_ts.pop_front());
                end
            end
        end else begin
            ts_pending = 0;
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic k, input logic l, output int acc_cyc);
        int t;
        bit hs;
        t = 0;
        hs = 0;
        acc_cyc = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!hs) begin
            @(negedge clk);
            hs = s_if.tready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            t++;
            if (!hs && t > 2000) abort_run("s_handshake");
        end
        s_if.tvalid = 1'b0;
    endtask

    // Reference model: last D beats are the timestamp (LSB first), the rest is the frame.
    task automatic send_pkt(input logic [7:0] b[$], input logic k[$], input bit gaps);
        int n;
        int ac;
        logic [TSW-1:0] ts;
        logic lst;
        n = b.size();
        if (n <= D) begin
            exp_runt++;
        end else begin
            for (int i = 0; i < n - D; i++) begin
                lst = (i == n - D - 1);
                exp_frame.push_back({lst, k[i], b[i]});
            end
            ts = '0;
            for (int j = 0; j < D; j++) ts[j*DW +: DW] = b[n-D+j];
            exp_ts.push_back(ts);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_beat(b[i], k[i], (i == n - 1), ac);
            if (i == 0) first_cyc = ac;
        end
    endtask

    task automatic rand_pkt(input int n, output logic [7:0] b[$], output logic k[$]);
        b = {};
        k = {};
        for (int i = 0; i < n; i++) begin
            b.push_back(8'($urandom));
            k.push_back(1'($urandom_range(1)));
        end
    endtask

    initial begin
        logic [7:0] b[$];
        logic       k[$];
        logic [7:0] b2[$];
        logic       k2[$];
        logic [63:0] wd[5];
        logic [7:0]  wk[5];
        int ac;
        int t;
        bit hs;

        s_if.tvalid = 0; s_if.tdata = 0; s_if.tkeep = 0; s_if.tlast = 0;
        ws_if.tvalid = 0; ws_if.tdata = 0; ws_if.tkeep = 0; ws_if.tlast = 0;
        m_if.tready = 0; t_if.tready = 0;
        wm_if.tready = 1; wt_if.tready = 1;

        #12;
        check("rst_s_ready", s_if.tready, 0);
        check("rst_m_valid", m_if.tvalid, 0);
        check("rst_ts_valid", t_if.tvalid, 0);
        check("rst_runt", runt_drop, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("s_ready_after_rst", s_if.tready, 1);

        // nominal packet
        b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
              8'h06, 8'h07, 8'h08, 8'h09};
        k = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_pkt(b, k, 0);
        check("ts_valid_next", t_if.tvalid, 1);
        check("ts_value", t_if.tdata, 72'h090807060504030201);
        repeat (2) @(posedge clk);
        #1;

        // runt packet of exactly D beats, then a normal packet
        rand_pkt(D, b, k);
        send_pkt(b, k, 0);
        @(negedge clk);
        check("runt_pulse", runt_drop, 1);
        @(negedge clk);
        check("runt_pulse_end", runt_drop, 0);
        @(posedge clk);
        #1;
        rand_pkt(20, b, k);
        send_pkt(b, k, 0);

        // frame backpressure 1010...
        m_mode = 1;
        rand_pkt(64 + D, b, k);
        send_pkt(b, k, 0);
        m_mode = 2;

        // timestamp stall with the next packet already pending
        ts_mode = 1;
        rand_pkt(15, b, k);
        send_pkt(b, k, 0);
        rand_pkt(12, b2, k2);
        fork
            send_pkt(b2, k2, 0);
            begin
                repeat (20) begin
                    @(negedge clk);
                    check("stall_s_ready", s_if.tready, 0);
                end
                ts_mode = 2;
            end
        join
        check("restart_gap", first_cyc, ts_hs_cyc + 1);

        // reset while a frame beat is presented and blocked
        repeat (3) @(posedge clk);
        #1;
        m_mode = 3;
        for (int i = 0; i < D; i++) drive_beat(8'($urandom), 1'b1, 1'b0, ac);
        s_if.tdata = 8'hA5; s_if.tkeep = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_m_valid", m_if.tvalid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_m_valid", m_if.tvalid, 0);
        check("async_rst_s_ready", s_if.tready, 0);
        check("async_rst_ts_valid", t_if.tvalid, 0);
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b1;
        m_mode = 2;
        @(posedge clk);
        #1;
        rand_pkt(20, b, k);
        send_pkt(b, k, 0);

        // randomized traffic
        for (int p = 0; p < 25; p++) begin
            m_mode  = $urandom_range(2);
            ts_mode = ($urandom_range(1) == 0) ? 0 : 2;
            rand_pkt($urandom_range(1, 40), b, k);
            send_pkt(b, k, 1'($urandom_range(1)));
        end

        m_mode = 2;
        ts_mode = 2;
        t = 0;
        while ((exp_frame.size() != 0 || exp_ts.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_queue_empty", exp_frame.size(), 0);
        check("ts_queue_empty", exp_ts.size(), 0);
        check("runt_count", got_runt, exp_runt);

        // wide bus: 3 frame beats (last keep 0x0F) then 2 timestamp beats
        for (int i = 0; i < 5; i++) begin
            wd[i] = {$urandom, $urandom};
            wk[i] = 8'($urandom);
        end
        wk[0] = 8'hFF; wk[1] = 8'hFF; wk[2] = 8'h0F;
        for (int i = 0; i < 3; i++) wexp_frame.push_back({(i == 2), wk[i], wd[i]});
        wexp_ts.push_back({wd[4], wd[3]});
        for (int i = 0; i < 5; i++) begin
            ws_if.tdata = wd[i]; ws_if.tkeep = wk[i]; ws_if.tlast = (i == 4); ws_if.tvalid = 1'b1;
            t = 0;
            hs = 0;
            while (!hs) begin
                @(negedge clk);
                hs = ws_if.tready;
                @(posedge clk);
                #1;
                t++;
                if (!hs && t > 50) abort_run("wide_handshake");
            end
        end
        ws_if.tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wide_frame_empty", wexp_frame.size(), 0);
        check("wide_ts_empty", wexp_ts.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
